// File: rtl/ws2812_receiver_if.sv
// rtl/ws2812_receiver_if.sv - pixel/frame event bundle produced by the WS2812 receiver
interface ws2812_receiver_if;
  logic        pixel_valid;
  logic [23:0] pixel_data;
  logic [15:0] pixel_idx;
  logic        frame_done;
  logic [15:0] frame_leds;
  logic        error;
  logic        busy;

  modport master (
    output pixel_valid, pixel_data, pixel_idx, frame_done, frame_leds, error, busy
  );

  modport slave (
    input pixel_valid, pixel_data, pixel_idx, frame_done, frame_leds, error, busy
  );
endinterface

// File: rtl/ws2812_receiver.sv
// rtl/ws2812_receiver.sv - WS2812 pulse-width decoder into pixel words and a frame buffer
module ws2812_receiver #(
  parameter int LED_COUNT    = 8,
  parameter int BIT_THRESH   = 26,
  parameter int MIN_HIGH     = 5,
  parameter int MAX_HIGH     = 50,
  parameter int RESET_CYCLES = 2500
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   din,
  output logic [LED_COUNT*24-1:0] data,
  ws2812_receiver_if.master      px
);

  typedef enum logic [1:0] {ALIGN, IDLE, HIGH, LOW} state_t;

  localparam logic [16:0] CNT_MAX = 17'(RESET_CYCLES);

  state_t      state_q, state_d;
  logic        sync1_q, din_s_q, din_d_q;
  logic [16:0] cnt_q, cnt_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [23:0] pixel_data_q, pixel_data_d;
  logic [15:0] pixel_idx_q, pixel_idx_d;
  logic [15:0] frame_leds_q, frame_leds_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic [LED_COUNT*24-1:0] data_q;

  logic        rise;
  logic        bit_val;
  logic        data_we;
  logic [16:0] cnt_inc;
  logic [23:0] shift_new;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      din_s_q <= 1'b0;
      din_d_q <= 1'b0;
    end else begin
      sync1_q <= din;
      din_s_q <= sync1_q;
      din_d_q <= din_s_q;
    end
  end

  // Next-state decode: pulse-width classification, pixel assembly, frame end
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_idx_d     = bit_idx_q;
    pix_cnt_d     = pix_cnt_q;
    shift_d       = shift_q;
    pixel_data_d  = pixel_data_q;
    pixel_idx_d   = pixel_idx_q;
    frame_leds_d  = frame_leds_q;
    busy_d        = busy_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    error_d       = 1'b0;
    data_we       = 1'b0;
    rise          = din_s_q & ~din_d_q;
    cnt_inc       = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + 17'd1;
    bit_val       = (cnt_q >= 17'(BIT_THRESH));
    shift_new     = {shift_q[22:0], bit_val};

    case (state_q)
      ALIGN: begin
        busy_d = 1'b0;
        if (din_s_q) begin
          cnt_d = 17'd0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_MAX) state_d = IDLE;
        end
      end
      IDLE: begin
        busy_d = 1'b0;
        if (rise) begin
          cnt_d     = 17'd1;
          bit_idx_d = 5'd0;
          pix_cnt_d = 16'd0;
          busy_d    = 1'b1;
          state_d   = HIGH;
        end
      end
      HIGH: begin
        if (din_s_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc > 17'(MAX_HIGH)) begin
            // Line stuck high: resynchronise on a clean low interval
            error_d = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = 17'd0;
            state_d = ALIGN;
          end
        end else if (cnt_q < 17'(MIN_HIGH)) begin
          // Glitch; the current low cycle already counts toward alignment
          error_d = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 17'd1;
          state_d = ALIGN;
        end else begin
          shift_d = shift_new;
          cnt_d   = 17'd1;
          state_d = LOW;
          if (bit_idx_q == 5'd23) begin
            pixel_valid_d = 1'b1;
            pixel_data_d  = shift_new;
            pixel_idx_d   = pix_cnt_q;
            data_we       = (int'(pix_cnt_q) < LED_COUNT);
            pix_cnt_d     = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
            bit_idx_d     = 5'd0;
          end else begin
            bit_idx_d = bit_idx_q + 5'd1;
          end
        end
      end
      LOW: begin
        if (din_s_q) begin
          cnt_d   = 17'd1;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_MAX) begin
            // Reset interval: close the frame, flag any dangling partial pixel
            frame_done_d = 1'b1;
            frame_leds_d = pix_cnt_q;
            busy_d       = 1'b0;
            error_d      = (bit_idx_q != 5'd0);
            state_d      = IDLE;
          end
        end
      end
      default: state_d = ALIGN;
    endcase
  end

  // Decoder state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ALIGN;
      cnt_q         <= 17'd0;
      bit_idx_q     <= 5'd0;
      pix_cnt_q     <= 16'd0;
      shift_q       <= 24'd0;
      pixel_data_q  <= 24'd0;
      pixel_idx_q   <= 16'd0;
      frame_leds_q  <= 16'd0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      pix_cnt_q     <= pix_cnt_d;
      shift_q       <= shift_d;
      pixel_data_q  <= pixel_data_d;
      pixel_idx_q   <= pixel_idx_d;
      frame_leds_q  <= frame_leds_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      error_q       <= error_d;
      busy_q        <= busy_d;
    end
  end

  // Frame buffer: only slots below LED_COUNT are written, the rest persist
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      for (int i = 0; i < LED_COUNT; i++) begin
        if (data_we && (pix_cnt_q == 16'(i))) data_q[i*24 +: 24] <= shift_new;
      end
    end
  end

  assign data           = data_q;
  assign px.pixel_valid = pixel_valid_q;
  assign px.pixel_data  = pixel_data_q;
  assign px.pixel_idx   = pixel_idx_q;
  assign px.frame_done  = frame_done_q;
  assign px.frame_leds  = frame_leds_q;
  assign px.error       = error_q;
  assign px.busy        = busy_q;

endmodule

// File: tb/tb_ws2812_receiver.sv
// tb/tb_ws2812_receiver.sv - directed bench for the WS2812 receiver
module tb_ws2812_receiver;
  localparam int RC = 2500;

  logic         clk = 1'b0;
  logic         reset;
  logic         din;
  logic [191:0] data;

  ws2812_receiver_if rx_if ();

  ws2812_receiver dut (
    .clk   (clk),
    .reset (reset),
    .din   (din),
    .data  (data),
    .px    (rx_if)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Event monitor
  int          pv_cnt = 0, fd_cnt = 0, err_cnt = 0, overlap = 0, fd_with_err = 0;
  logic [23:0] pix_log [64];
  logic [15:0] idx_log [64];
  logic [15:0] last_leds = 16'd0;

  always @(negedge clk) begin
    if (rx_if.pixel_valid === 1'b1) begin
      pix_log[pv_cnt % 64] = rx_if.pixel_data;
      idx_log[pv_cnt % 64] = rx_if.pixel_idx;
      pv_cnt++;
      if (rx_if.frame_done === 1'b1 || rx_if.error === 1'b1) overlap++;
    end
    if (rx_if.frame_done === 1'b1) begin
      fd_cnt++;
      last_leds = rx_if.frame_leds;
      if (rx_if.error === 1'b1) fd_with_err++;
    end
    if (rx_if.error === 1'b1) err_cnt++;
  end

  task automatic send_bit(input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [23:0] p, input bit last);
    for (int i = 23; i >= 0; i--)
      send_bit(p[i] ? 35 : 17, (last && i == 0) ? 0 : (p[i] ? 27 : 45));
  endtask

  task automatic wait_low(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Waits for frame_done after the final falling edge; returns cycles taken
  task automatic end_frame(output int k);
    k = 0;
    din = 1'b0;
    while (k < RC + 50) begin
      @(negedge clk);
      k++;
      if (rx_if.frame_done === 1'b1) break;
    end
    repeat (5) @(negedge clk);
  endtask

  logic [191:0] exp_data;
  logic [23:0]  pxv [10];
  int pv0, fd0, er0, fe0, k;

  initial begin
    reset = 1'b0;
    din   = 1'b0;
    exp_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_data", data, 192'd0);
    check_eq("rst_outs", {rx_if.pixel_valid, rx_if.pixel_data, rx_if.pixel_idx, rx_if.frame_done,
                          rx_if.frame_leds, rx_if.error, rx_if.busy}, 192'd0);
    reset = 1'b1;
    wait_low(RC + 20);

    // Loopback-style frame of 8 pixels
    pxv[0] = 24'hFF0000; pxv[1] = 24'h00FF00; pxv[2] = 24'h0000FF; pxv[3] = 24'hFFFFFF;
    pxv[4] = 24'h000000; pxv[5] = 24'h123456; pxv[6] = 24'h5A5A5A; pxv[7] = 24'hA5A5A5;
    pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
    for (int i = 0; i < 8; i++) begin
      send_pixel(pxv[i], i == 7);
      exp_data[i*24 +: 24] = pxv[i];
    end
    end_frame(k);
    check_eq("t1_pv_count", 192'(pv_cnt - pv0), 192'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t1_pix%0d", i), 192'(pix_log[(pv0 + i) % 64]), 192'(pxv[i]));
      check_eq($sformatf("t1_idx%0d", i), 192'(idx_log[(pv0 + i) % 64]), 192'(i));
    end
    check_eq("t1_data", data, exp_data);
    check_eq("t1_fd_count", 192'(fd_cnt - fd0), 192'd1);
    check_eq("t1_fd_delay", 192'(k), 192'(RC + 2));
    check_eq("t1_leds", 192'(last_leds), 192'd8);
    check_eq("t1_err", 192'(err_cnt - er0), 192'd0);
    check_eq("t1_idle_busy", 192'(rx_if.busy), 192'd0);

    // Width sweep: 5,25,26,50 inside one pixel -> 0,0,1,1
    pv0 = pv_cnt; er0 = err_cnt;
    send_bit(5, 57); send_bit(25, 37); send_bit(26, 36); send_bit(50, 12);
    for (int i = 0; i < 20; i++) send_bit(17, (i == 19) ? 0 : 45);
    end_frame(k);
    exp_data[0 +: 24] = 24'h300000;
    check_eq("t2_pix", 192'(pix_log[pv0 % 64]), 192'h300000);
    check_eq("t2_err_ok", 192'(err_cnt - er0), 192'd0);
    check_eq("t2_data", data, exp_data);
    // Width 4 and width 51 are rejected
    pv0 = pv_cnt; fd0 = fd_cnt; er0 = err_cnt;
    send_bit(4, 0);
    wait_low(RC + 20);
    check_eq("t2_w4_err", 192'(err_cnt - er0), 192'd1);
    send_bit(51, 0);
    wait_low(RC + 20);
    check_eq("t2_w51_err", 192'(err_cnt - er0), 192'd2);
    check_eq("t2_bad_fd", 192'(fd_cnt - fd0), 192'd0);
    check_eq("t2_bad_pv", 192'(pv_cnt - pv0), 192'd0);

    // Release from reset while the line toggles
    reset = 1'b0;
    exp_data = '0;
    send_bit(35, 27);
    reset = 1'b1;
    pv0 = pv_cnt;
    for (int i = 0; i < 3; i++) send_pixel(24'hC0FFEE, 1'b0);
    check_eq("t3_no_pv", 192'(pv_cnt - pv0), 192'd0);
    wait_low(RC + 20);
    pv0 = pv_cnt; fd0 = fd_cnt;
    send_pixel(24'h13579B, 1'b0);
    send_pixel(24'h2468AC, 1'b1);
    end_frame(k);
    exp_data[0 +: 24]  = 24'h13579B;
    exp_data[24 +: 24] = 24'h2468AC;
    check_eq("t3_pv", 192'(pv_cnt - pv0), 192'd2);
    check_eq("t3_data", data, exp_data);
    check_eq("t3_leds", 192'(last_leds), 192'd2);

    // Ten pixels into an eight-slot buffer
    pv0 = pv_cnt; fd0 = fd_cnt;
    for (int i = 0; i < 10; i++) begin
      pxv[i] = {8'(i * 17), 8'(i * 3 + 1), 8'(255 - i)};
      send_pixel(pxv[i], i == 9);
      if (i < 8) exp_data[i*24 +: 24] = pxv[i];
    end
    end_frame(k);
    check_eq("t4_pv", 192'(pv_cnt - pv0), 192'd10);
    check_eq("t4_last_idx", 192'(idx_log[(pv0 + 9) % 64]), 192'd9);
    check_eq("t4_last_pix", 192'(pix_log[(pv0 + 9) % 64]), 192'(pxv[9]));
    check_eq("t4_leds", 192'(last_leds), 192'd10);
    check_eq("t4_data", data, exp_data);

    // 30 bits: one pixel plus a partial
    pv0 = pv_cnt; fd0 = fd_cnt; fe0 = fd_with_err;
    send_pixel(24'hC3C3C3, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(35, (i == 5) ? 0 : 27);
    end_frame(k);
    exp_data[0 +: 24] = 24'hC3C3C3;
    check_eq("t5_pv", 192'(pv_cnt - pv0), 192'd1);
    check_eq("t5_fd", 192'(fd_cnt - fd0), 192'd1);
    check_eq("t5_fd_err", 192'(fd_with_err - fe0), 192'd1);
    check_eq("t5_leds", 192'(last_leds), 192'd1);
    check_eq("t5_data", data, exp_data);

    // Reset during bit 12 of pixel 3
    for (int i = 0; i < 3; i++) send_pixel(24'h0F0F0F, 1'b0);
    for (int i = 0; i < 12; i++) send_bit(35, 27);
    din = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("t6_busy_mid", 192'(rx_if.busy), 192'd1);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_data", data, 192'd0);
    check_eq("t6_rst_outs", {rx_if.pixel_valid, rx_if.pixel_data, rx_if.pixel_idx, rx_if.frame_done,
                             rx_if.frame_leds, rx_if.error, rx_if.busy}, 192'd0);
    @(negedge clk);
    din = 1'b0;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    send_bit(35, 20);
    check_eq("t6_align_busy", 192'(rx_if.busy), 192'd0);

    check_eq("overlap", 192'(overlap), 192'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
